decode_seq: RTL and testbench
=============================

Name: decode_seq

Overview:
- Parametrised successor to the single-cycle 8-bit instruction decoder.
- Decodes the full 14-bit mid-range instruction word: byte, bit, literal and control classes.
- Generates its own four-phase Q1–Q4 sequencing internally instead of taking four external phase clocks.
- Adds skip and branch handling with pipeline flush, plus a valid/ready fetch handshake. Sits between the fetch stage and the ALU mux, RAM and W register.

Parameters:
- FADDR_W, 7: file-register address width; inst_in[FADDR_W-1:0] is f.
- JADDR_W, 11: jump target width for CALL/GOTO.
- FLUSH_CYCLES, 4: bubble length in clk cycles after a taken skip or jump; legal range 1–8.
- SKIP_EN, 1: 0 disables skip evaluation, so skip instructions behave as their non-skipping ALU ops.

Ports:
- clk  in  1  single system clock
- rst  in  1  asynchronous, active-high reset
- inst_in  in  14  instruction word from fetch
- inst_valid  in  1  inst_in valid
- inst_ready  out  1  decoder can accept inst_in this cycle
- alu_zero  in  1  ALU result-zero flag, sampled at Q3
- bit_val  in  1  tested file bit, sampled at Q3
- q_phase  out  2  current phase, 0..3 = Q1..Q4
- alu_op  out  4  ALU operation code
- d  out  1  destination: 1 = f, 0 = W
- switch_a_m  out  1  ALU mux select: 1 = f, 0 = literal
- act_ram  out  1  RAM access enable
- write_en  out  1  result write strobe
- f_addr  out  FADDR_W  file address
- lit  out  8  literal k
- bit_number  out  3  bit index for bit ops
- jump  out  1  one-cycle jump request
- jump_addr  out  JADDR_W  jump target
- flushing  out  1  decoder is inserting bubbles

Behaviour:
- States: IDLE, EXEC, FLUSH.
- Reset values (asynchronous, effective immediately, including mid-instruction):
  - state = IDLE, q_phase = 0, alu_op = 1 (NOP/pass).
  - d, switch_a_m, act_ram, write_en, jump, flushing all 0.
  - f_addr, lit, bit_number, jump_addr all 0.
  - inst_ready = 1 from the first clk edge after rst deasserts.
- Handshake:
  - A transfer occurs on a clk edge where inst_valid && inst_ready.
  - inst_ready = 1 in IDLE, and in EXEC at q_phase == 3 when no skip or jump is taken; 0 otherwise.
- On transfer:
  - The instruction is latched, state goes to EXEC, q_phase = 0.
  - Decoded outputs are registered and are stable from Q1 through Q4 (one-cycle latency from the transfer edge).
- EXEC:
  - q_phase increments once per clk.
  - write_en = 1 in Q3 and Q4 only, and only for writing instructions.
- End of Q4 (q_phase == 3):
  - If a skip is taken or the instruction is CALL/GOTO: go to FLUSH.
  - Else if inst_valid: accept the next instruction back-to-back with no bubble.
  - Else: go to IDLE.
- FLUSH:
  - Lasts FLUSH_CYCLES clks with alu_op = 1, write_en = 0, act_ram = 0, flushing = 1. Then IDLE.
  - inst_valid is ignored during FLUSH; fetch is discarding the skipped or fall-through word.
- Decode, inst_in[13:12] = 00, byte class:
  - act_ram = 1, switch_a_m = 1, d = inst[7], f_addr = inst[FADDR_W-1:0].
  - inst[11:8] → alu_op:
    - 0111 ADDWF → 2; 0101 ANDWF → 4; 0001 CLR → 9; 1001 COMF → 12.
    - 0011 DECF → 6; 1011 DECFSZ → 6; 1010 INCF → 5; 1111 INCFSZ → 5.
    - 0100 IORWF → 10; 1000 MOVF → 0; 0000 MOVWF/NOP → 1; 1101 RLF → 8.
    - 1100 RRF → 15; 0010 SUBWF → 3; 1110 SWAPF → 11; 0110 XORWF → 7.
  - DECFSZ/INCFSZ: skip is taken when alu_zero == 1 at Q3.
- Decode, 01, bit class:
  - act_ram = 1, switch_a_m = 1, d = 1, bit_number = inst[9:7].
  - inst[11:10] = 00 BCF → 14; 01 BSF → 13 (both write).
  - 10 BTFSC → alu_op 1, write_en held 0, skip when bit_val == 0 at Q3.
  - 11 BTFSS → alu_op 1, write_en held 0, skip when bit_val == 1 at Q3.
- Decode, 11, literal class:
  - act_ram = 0, switch_a_m = 0, d = 0, lit = inst[7:0].
  - inst[11:8] → alu_op:
    - 00xx MOVLW → 0; 1000 IORLW → 10; 1001 ANDLW → 4; 1010 XORLW → 7.
    - 110x SUBLW → 3; 111x ADDLW → 2; all other codes → 1.
- Decode, 10, control class:
  - alu_op = 1, write_en = 0, act_ram = 0.
  - jump_addr = inst[JADDR_W-1:0].
  - jump pulses for one clk at Q4. inst[11] = 0 is CALL, 1 is GOTO; both flush.
- SKIP_EN = 0: no skip is ever taken, and FLUSH is entered only for CALL/GOTO.
- Flag sampling: alu_zero/bit_val changes outside Q3 have no effect.

Test Plan:
- rst pulsed mid-EXEC at q_phase = 2 → outputs return to reset values in the same cycle without a clock edge; inst_ready = 1 after the first post-reset edge.
- ADDWF f=0x25, d=1 (14'h07A5), inst_valid held high → alu_op = 2, d = 1, f_addr = 0x25, write_en high exactly in Q3/Q4; the next instruction is accepted at Q4 with no bubble.
- MOVLW 0x5A (14'h305A) → switch_a_m = 0, act_ram = 0, lit = 0x5A, alu_op = 0, d = 0.
- DECFSZ f=0x10 (14'h0B90), alu_zero = 1 at Q3 → flushing = 1 for 4 clks, write_en = 0 throughout the flush, inst_ready = 0 during the flush.
- Same instruction with alu_zero = 0, and alu_zero = 1 asserted only in Q2 → no skip, back-to-back fetch.
- BTFSS bit 3, f=0x03 (14'h1D83) with bit_val = 1 → skip, write_en never high. GOTO 0x123 (14'h2923) → jump = 1 only in Q4, jump_addr = 0x123, followed by FLUSH_CYCLES bubbles.

Source files
------------

// File: rtl/decode_seq.sv
// 14-bit mid-range instruction decoder with an internal Q1-Q4 phase sequencer,
// skip/branch pipeline flush and a valid/ready handshake toward fetch.
module decode_seq #(
  parameter int FADDR_W      = 7,
  parameter int JADDR_W      = 11,
  parameter int FLUSH_CYCLES = 4,
  parameter int SKIP_EN      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [13:0]        inst_in,
  input  logic               inst_valid,
  output logic               inst_ready,
  input  logic               alu_zero,
  input  logic               bit_val,
  output logic [1:0]         q_phase,
  output logic [3:0]         alu_op,
  output logic               d,
  output logic               switch_a_m,
  output logic               act_ram,
  output logic               write_en,
  output logic [FADDR_W-1:0] f_addr,
  output logic [7:0]         lit,
  output logic [2:0]         bit_number,
  output logic               jump,
  output logic [JADDR_W-1:0] jump_addr,
  output logic               flushing
);

  typedef enum logic [1:0] {IDLE, EXEC, FLUSH} state_e;
  typedef enum logic [1:0] {SK_NONE, SK_ZERO, SK_BIT_CLR, SK_BIT_SET} skip_e;

  localparam logic [3:0] OP_PASS    = 4'd1;
  localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

  state_e               state_q;
  logic [1:0]           q_phase_q;
  logic [3:0]           alu_op_q;
  logic                 d_q, switch_a_m_q, act_ram_q, write_en_q;
  logic [FADDR_W-1:0]   f_addr_q;
  logic [7:0]           lit_q;
  logic [2:0]           bit_number_q;
  logic                 jump_q, flushing_q;
  logic [JADDR_W-1:0]   jump_addr_q;
  logic                 ready_en_q, writes_q, ctrl_q, skip_q;
  skip_e                skip_kind_q;
  logic [2:0]           flush_cnt_q;

  logic [3:0]           alu_op_d;
  logic                 writes_d;
  skip_e                skip_kind_d;
  logic                 skip_hit, take;

  always_comb begin
    // NOTE: every signal gets a default first so no decode path can infer a latch.
    alu_op_d    = OP_PASS;
    writes_d    = 1'b0;
    skip_kind_d = SK_NONE;
    case (inst_in[13:12])
      2'b00: begin
        // Only the NOP encoding (0000 with d=0) of the byte class writes nothing.
        writes_d = (inst_in[11:8] != 4'b0000) || inst_in[7];
        case (inst_in[11:8])
          4'b0001: alu_op_d = 4'd9;
          4'b0010: alu_op_d = 4'd3;
          4'b0011: alu_op_d = 4'd6;
          4'b0100: alu_op_d = 4'd10;
          4'b0101: alu_op_d = 4'd4;
          4'b0110: alu_op_d = 4'd7;
          4'b0111: alu_op_d = 4'd2;
          4'b1000: alu_op_d = 4'd0;
          4'b1001: alu_op_d = 4'd12;
          4'b1010: alu_op_d = 4'd5;
          4'b1011: alu_op_d = 4'd6;
          4'b1100: alu_op_d = 4'd15;
          4'b1101: alu_op_d = 4'd8;
          4'b1110: alu_op_d = 4'd11;
          4'b1111: alu_op_d = 4'd5;
          default: alu_op_d = OP_PASS;
        endcase
        if (inst_in[11:8] == 4'b1011 || inst_in[11:8] == 4'b1111) skip_kind_d = SK_ZERO;
      end
      2'b01: begin
        case (inst_in[11:10])
          2'b00:   begin alu_op_d = 4'd14; writes_d = 1'b1; end
          2'b01:   begin alu_op_d = 4'd13; writes_d = 1'b1; end
          2'b10:   skip_kind_d = SK_BIT_CLR;
          default: skip_kind_d = SK_BIT_SET;
        endcase
      end
      2'b11: begin
        casez (inst_in[11:8])
          4'b00??: alu_op_d = 4'd0;
          4'b1000: alu_op_d = 4'd10;
          4'b1001: alu_op_d = 4'd4;
          4'b1010: alu_op_d = 4'd7;
          4'b110?: alu_op_d = 4'd3;
          4'b111?: alu_op_d = 4'd2;
          default: alu_op_d = OP_PASS;
        endcase
        writes_d = (alu_op_d != OP_PASS);
      end
      default: ;
    endcase
    if (SKIP_EN == 0) skip_kind_d = SK_NONE;
  end

  always_comb begin
    case (skip_kind_q)
      SK_ZERO:    skip_hit = alu_zero;
      SK_BIT_CLR: skip_hit = !bit_val;
      SK_BIT_SET: skip_hit = bit_val;
      default:    skip_hit = 1'b0;
    endcase
  end

  // Ready depends on registered state only, so fetch sees no combinational loop.
  assign inst_ready = ready_en_q &&
                      ((state_q == IDLE) ||
                       (state_q == EXEC && q_phase_q == 2'd3 && !skip_q && !ctrl_q));
  assign take = inst_valid && inst_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      q_phase_q    <= 2'd0;
      alu_op_q     <= OP_PASS;
      d_q          <= 1'b0;
      switch_a_m_q <= 1'b0;
      act_ram_q    <= 1'b0;
      write_en_q   <= 1'b0;
      f_addr_q     <= '0;
      lit_q        <= 8'd0;
      bit_number_q <= 3'd0;
      jump_q       <= 1'b0;
      jump_addr_q  <= '0;
      flushing_q   <= 1'b0;
      ready_en_q   <= 1'b0;
      writes_q     <= 1'b0;
      ctrl_q       <= 1'b0;
      skip_q       <= 1'b0;
      skip_kind_q  <= SK_NONE;
      flush_cnt_q  <= 3'd0;
    end else begin
      // NOTE: non-blocking assignments throughout, so later overrides in this block win cleanly.
      ready_en_q <= 1'b1;
      jump_q     <= 1'b0;
      case (state_q)
        IDLE: ;
        EXEC: begin
          q_phase_q  <= q_phase_q + 2'd1;
          write_en_q <= writes_q && (q_phase_q == 2'd1 || q_phase_q == 2'd2);
          if (q_phase_q == 2'd2) begin
            skip_q <= skip_hit;
            jump_q <= ctrl_q;
          end
          if (q_phase_q == 2'd3) begin
            if (skip_q || ctrl_q) begin
              state_q     <= FLUSH;
              flush_cnt_q <= FLUSH_LAST;
              alu_op_q    <= OP_PASS;
              act_ram_q   <= 1'b0;
              write_en_q  <= 1'b0;
              flushing_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        FLUSH: begin
          if (flush_cnt_q == 3'd0) begin
            state_q    <= IDLE;
            flushing_q <= 1'b0;
          end else begin
            flush_cnt_q <= flush_cnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (take) begin
        state_q     <= EXEC;
        q_phase_q   <= 2'd0;
        write_en_q  <= 1'b0;
        skip_q      <= 1'b0;
        alu_op_q    <= alu_op_d;
        writes_q    <= writes_d;
        skip_kind_q <= skip_kind_d;
        ctrl_q      <= (inst_in[13:12] == 2'b10);
        case (inst_in[13:12])
          2'b00: begin
            act_ram_q    <= 1'b1;
            switch_a_m_q <= 1'b1;
            d_q          <= inst_in[7];
            f_addr_q     <= inst_in[FADDR_W-1:0];
          end
          2'b01: begin
            act_ram_q    <= 1'b1;
            switch_a_m_q <= 1'b1;
            d_q          <= 1'b1;
            f_addr_q     <= inst_in[FADDR_W-1:0];
            bit_number_q <= inst_in[9:7];
          end
          2'b11: begin
            act_ram_q    <= 1'b0;
            switch_a_m_q <= 1'b0;
            d_q          <= 1'b0;
            lit_q        <= inst_in[7:0];
          end
          default: begin
            act_ram_q   <= 1'b0;
            jump_addr_q <= inst_in[JADDR_W-1:0];
          end
        endcase
      end
    end
  end

  assign q_phase    = q_phase_q;
  assign alu_op     = alu_op_q;
  assign d          = d_q;
  assign switch_a_m = switch_a_m_q;
  assign act_ram    = act_ram_q;
  assign write_en   = write_en_q;
  assign f_addr     = f_addr_q;
  assign lit        = lit_q;
  assign bit_number = bit_number_q;
  assign jump       = jump_q;
  assign jump_addr  = jump_addr_q;
  assign flushing   = flushing_q;

endmodule

// File: tb/tb_decode_seq.sv
// Scoreboard bench for decode_seq: the driver pushes the expected decode of each
// accepted instruction, and an independent monitor follows the phases and flushes.
module tb_decode_seq;

  localparam int FADDR_W      = 7;
  localparam int JADDR_W      = 11;
  localparam int FLUSH_CYCLES = 4;
  localparam int SKIP_EN      = 1;
  localparam int N_RANDOM     = 160;

  localparam logic [3:0] BYTE_OP [16] = '{4'd1, 4'd9, 4'd3, 4'd6, 4'd10, 4'd4, 4'd7, 4'd2,
                                          4'd0, 4'd12, 4'd5, 4'd6, 4'd15, 4'd8, 4'd11, 4'd5};

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [13:0]        inst_in = 14'd0;
  logic               inst_valid = 1'b0;
  logic               alu_zero = 1'b0;
  logic               bit_val = 1'b0;
  logic               inst_ready;
  logic [1:0]         q_phase;
  logic [3:0]         alu_op;
  logic               d, switch_a_m, act_ram, write_en, jump, flushing;
  logic [FADDR_W-1:0] f_addr;
  logic [7:0]         lit;
  logic [2:0]         bit_number;
  logic [JADDR_W-1:0] jump_addr;

  decode_seq #(
    .FADDR_W(FADDR_W), .JADDR_W(JADDR_W), .FLUSH_CYCLES(FLUSH_CYCLES), .SKIP_EN(SKIP_EN)
  ) dut (
    .clk(clk), .rst(rst), .inst_in(inst_in), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .alu_zero(alu_zero), .bit_val(bit_val), .q_phase(q_phase), .alu_op(alu_op), .d(d),
    .switch_a_m(switch_a_m), .act_ram(act_ram), .write_en(write_en), .f_addr(f_addr),
    .lit(lit), .bit_number(bit_number), .jump(jump), .jump_addr(jump_addr), .flushing(flushing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] word;
    logic [3:0]  az;
    logic [3:0]  bv;
    int          gap;
  } stim_t;

  typedef struct packed {
    logic [1:0]  cls;
    logic [3:0]  op;
    logic        d;
    logic        sam;
    logic        ram;
    logic [6:0]  faddr;
    logic [7:0]  lit;
    logic [2:0]  bitn;
    logic [10:0] jaddr;
    logic        writes;
    logic        skip;
    logic        ctrl;
  } exp_t;

  int    checks = 0;
  int    failures = 0;
  exp_t  sb_q[$];
  bit    mon_en = 1'b0;
  exp_t  mon_cur;
  int    mon_phase = -1;
  int    mon_flush_left = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction-set tables; flags are the Q3 samples.
  function automatic exp_t model(input logic [13:0] w, input logic az_q3, input logic bv_q3);
    exp_t e;
    int   sub;
    e     = '0;
    e.cls = w[13:12];
    sub   = int'(w[11:8]);
    case (w[13:12])
      2'b00: begin
        e.op = BYTE_OP[sub]; e.d = w[7]; e.sam = 1'b1; e.ram = 1'b1; e.faddr = w[6:0];
        e.writes = !(sub == 0 && !w[7]);
        e.skip   = (SKIP_EN != 0) && (sub == 11 || sub == 15) && az_q3;
      end
      2'b01: begin
        sub = int'(w[11:10]);
        e.op = (sub == 0) ? 4'd14 : (sub == 1) ? 4'd13 : 4'd1;
        e.d = 1'b1; e.sam = 1'b1; e.ram = 1'b1; e.faddr = w[6:0]; e.bitn = w[9:7];
        e.writes = (sub < 2);
        e.skip   = (SKIP_EN != 0) && ((sub == 2 && !bv_q3) || (sub == 3 && bv_q3));
      end
      2'b11: begin
        if (sub < 4)                    e.op = 4'd0;
        else if (sub == 8)              e.op = 4'd10;
        else if (sub == 9)              e.op = 4'd4;
        else if (sub == 10)             e.op = 4'd7;
        else if (sub == 12 || sub == 13) e.op = 4'd3;
        else if (sub >= 14)             e.op = 4'd2;
        else                            e.op = 4'd1;
        e.writes = !((sub >= 4 && sub <= 7) || sub == 11);
        e.lit = w[7:0];
      end
      default: begin
        e.op = 4'd1; e.jaddr = w[10:0]; e.ctrl = 1'b1;
      end
    endcase
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_alu_op"}, alu_op, 1);
    check({tag, "_q_phase"}, q_phase, 0);
    check({tag, "_d"}, d, 0);
    check({tag, "_switch_a_m"}, switch_a_m, 0);
    check({tag, "_act_ram"}, act_ram, 0);
    check({tag, "_write_en"}, write_en, 0);
    check({tag, "_jump"}, jump, 0);
    check({tag, "_flushing"}, flushing, 0);
    check({tag, "_f_addr"}, f_addr, 0);
    check({tag, "_lit"}, lit, 0);
    check({tag, "_bit_number"}, bit_number, 0);
    check({tag, "_jump_addr"}, jump_addr, 0);
    check({tag, "_inst_ready"}, inst_ready, 0);
  endtask

  // Monitor: samples 1 unit after each falling edge, well clear of the active edge.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (mon_phase >= 0) begin
          check("q_phase", q_phase, mon_phase);
          check("alu_op", alu_op, mon_cur.op);
          check("act_ram", act_ram, mon_cur.ram);
          check("flushing_exec", flushing, 0);
          check("write_en", write_en, mon_cur.writes && mon_phase >= 2);
          check("jump", jump, mon_cur.ctrl && mon_phase == 3);
          check("inst_ready_exec", inst_ready, mon_phase == 3 && !mon_cur.skip && !mon_cur.ctrl);
          case (mon_cur.cls)
            2'b00: begin
              check("d", d, mon_cur.d);
              check("switch_a_m", switch_a_m, mon_cur.sam);
              check("f_addr", f_addr, mon_cur.faddr);
            end
            2'b01: begin
              check("d", d, mon_cur.d);
              check("switch_a_m", switch_a_m, mon_cur.sam);
              check("f_addr", f_addr, mon_cur.faddr);
              check("bit_number", bit_number, mon_cur.bitn);
            end
            2'b11: begin
              check("d", d, mon_cur.d);
              check("switch_a_m", switch_a_m, mon_cur.sam);
              check("lit", lit, mon_cur.lit);
            end
            default: check("jump_addr", jump_addr, mon_cur.jaddr);
          endcase
          if (mon_phase == 3) begin
            if (mon_cur.skip || mon_cur.ctrl) mon_flush_left = FLUSH_CYCLES;
            mon_phase = -1;
          end else begin
            mon_phase++;
          end
        end else if (mon_flush_left > 0) begin
          check("flushing", flushing, 1);
          check("flush_alu_op", alu_op, 1);
          check("flush_write_en", write_en, 0);
          check("flush_act_ram", act_ram, 0);
          check("flush_jump", jump, 0);
          check("flush_inst_ready", inst_ready, 0);
          mon_flush_left--;
        end else begin
          check("idle_flushing", flushing, 0);
          check("idle_write_en", write_en, 0);
          check("idle_jump", jump, 0);
          check("idle_inst_ready", inst_ready, 1);
        end
        if (inst_valid && inst_ready) begin
          check("sb_has_entry", sb_q.size() != 0, 1);
          if (sb_q.size() != 0) begin
            mon_cur   = sb_q.pop_front();
            mon_phase = 0;
          end
        end
      end
    end
  end

  initial begin : driver
    stim_t stim[$];
    stim_t s;
    int    tries;

    #1 rst = 1'b1;
    #2 check_reset_values("rst");
    @(negedge clk);
    rst = 1'b0;
    #1 check("ready_before_edge", inst_ready, 0);
    @(posedge clk);
    #1 check("ready_after_edge", inst_ready, 1);

    // Reset asserted mid-instruction at Q3 must clear outputs without a clock edge.
    @(negedge clk);
    inst_in = 14'h07A5; inst_valid = 1'b1;
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_rst_q_phase", q_phase, 2);
    check("pre_rst_alu_op", alu_op, 2);
    check("pre_rst_write_en", write_en, 1);
    #2 rst = 1'b1;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check("ready_after_midrst", inst_ready, 1);

    stim.push_back('{14'h07A5, 4'b0000, 4'b0000, 0});  // ADDWF 0x25,f
    stim.push_back('{14'h305A, 4'b0000, 4'b0000, 0});  // MOVLW 0x5A back-to-back
    stim.push_back('{14'h0B90, 4'b0100, 4'b0000, 0});  // DECFSZ, zero at Q3 -> skip
    stim.push_back('{14'h0B90, 4'b0000, 4'b0000, 0});  // DECFSZ, no skip
    stim.push_back('{14'h0B90, 4'b0010, 4'b0000, 0});  // zero only at Q2 -> no skip
    stim.push_back('{14'h3000, 4'b0000, 4'b0000, 0});
    stim.push_back('{14'h1D83, 4'b0000, 4'b0100, 1});  // BTFSS bit 3, set -> skip
    stim.push_back('{14'h2923, 4'b0000, 4'b0000, 0});  // GOTO 0x123
    stim.push_back('{14'h2045, 4'b0000, 4'b0000, 2});  // CALL 0x045
    stim.push_back('{14'h1983, 4'b0000, 4'b1011, 0});  // BTFSC bit 3, clear at Q3 -> skip
    stim.push_back('{14'h0080, 4'b1111, 4'b1111, 0});  // NOP-like MOVWF with d=1
    stim.push_back('{14'h0000, 4'b1111, 4'b1111, 0});  // NOP: no write
    for (int i = 0; i < N_RANDOM; i++) begin
      s.word = 14'($urandom);
      s.az   = 4'($urandom_range(0, 15));
      s.bv   = 4'($urandom_range(0, 15));
      s.gap  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      stim.push_back(s);
    end

    @(negedge clk);
    mon_en = 1'b1;
    foreach (stim[i]) begin
      s = stim[i];
      if (s.gap > 0) begin
        inst_valid = 1'b0;
        repeat (s.gap) @(negedge clk);
      end
      inst_in    = s.word;
      inst_valid = 1'b1;
      tries      = 0;
      while (!inst_ready && tries < 20) begin
        @(negedge clk);
        tries++;
      end
      if (!inst_ready) begin
        checks++;
        failures++;
        $display("FAIL ready_timeout: inst_ready still 0 after %0d cycles, expected 1", tries);
        break;
      end
      sb_q.push_back(model(s.word, s.az[2], s.bv[2]));
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        alu_zero = s.az[k];
        bit_val  = s.bv[k];
      end
    end
    inst_valid = 1'b0;
    repeat (16) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: still running at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
